// File: rtl/sudoku_board_checker.sv
// Sudoku board storage and solution checker: captures row/col/value writes from
// FSM flag edges and scans all 27 row/column/box groups one cell per cycle.
module sudoku_board_checker (
    input  logic       clka,
    input  logic       restart_n,
    input  logic       set_board_flag,
    input  logic       row_flag,
    input  logic       col_flag,
    input  logic       val_flag,
    input  logic       check_flag,
    input  logic [3:0] data_in,
    input  logic [3:0] rd_row,
    input  logic [3:0] rd_col,
    output logic [3:0] rd_val,
    output logic       solved,
    output logic       busy,
    output logic       check_done,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam int F_ROW = 0;
    localparam int F_COL = 1;
    localparam int F_VAL = 2;
    localparam int F_CHK = 3;
    localparam int F_SET = 4;

    state_t     state;
    logic [3:0] cells [0:80];
    logic [3:0] row_reg;
    logic [3:0] col_reg;
    logic [4:0] g_cnt;
    logic [3:0] i_cnt;
    logic [8:0] mask;
    logic       fail;

    logic [4:0] flag_p0;
    logic [4:0] flag_p1;
    logic [3:0] data_p0;
    logic [4:0] flag_rise;

    logic [3:0] cur_val;
    logic [8:0] cur_bit;
    logic       fail_next;

    function automatic logic [6:0] cell_idx(input logic [3:0] r, input logic [3:0] c);
        return {3'b000, r} * 7'd9 + {3'b000, c};
    endfunction

    function automatic logic [6:0] scan_addr(input logic [4:0] g, input logic [3:0] i);
        int gi, ii, r, c, b;
        gi = int'(g);
        ii = int'(i);
        if (gi < 9) begin
            r = gi;
            c = ii;
        end else if (gi < 18) begin
            r = ii;
            c = gi - 9;
        end else begin
            b = gi - 18;
            r = 3 * (b / 3) + ii / 3;
            c = 3 * (b % 3) + ii % 3;
        end
        return 7'(r * 9 + c);
    endfunction

    function automatic logic [8:0] seen_bit(input logic [3:0] v);
        if (v == 4'd0 || v > 4'd9)
            return 9'd0;
        return 9'd1 << (v - 4'd1);
    endfunction

    // Flags and data are sampled together; the action happens one edge later.
    assign flag_rise = flag_p0 & ~flag_p1;

    always_comb begin
        cur_val   = cells[scan_addr(g_cnt, i_cnt)];
        cur_bit   = seen_bit(cur_val);
        fail_next = fail | (cur_bit == 9'd0) | (|(mask & cur_bit));
    end

    always_comb begin
        rd_val = 4'd0;
        if (rd_row < 4'd9 && rd_col < 4'd9)
            rd_val = cells[cell_idx(rd_row, rd_col)];
    end

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            for (int k = 0; k < 81; k++)
                cells[k] <= 4'd0;
            state      <= IDLE;
            row_reg    <= 4'd0;
            col_reg    <= 4'd0;
            g_cnt      <= 5'd0;
            i_cnt      <= 4'd0;
            mask       <= 9'd0;
            fail       <= 1'b0;
            flag_p0    <= 5'd0;
            flag_p1    <= 5'd0;
            data_p0    <= 4'd0;
            solved     <= 1'b0;
            busy       <= 1'b0;
            check_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            flag_p0    <= {set_board_flag, check_flag, val_flag, col_flag, row_flag};
            flag_p1    <= flag_p0;
            data_p0    <= data_in;
            err        <= 1'b0;
            check_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (flag_rise[F_SET]) begin
                        for (int k = 0; k < 81; k++)
                            cells[k] <= 4'd0;
                        solved <= 1'b0;
                    end else if (flag_rise[F_CHK]) begin
                        state <= SCAN;
                        busy  <= 1'b1;
                        g_cnt <= 5'd0;
                        i_cnt <= 4'd0;
                        mask  <= 9'd0;
                        fail  <= 1'b0;
                    end else if (flag_rise[F_VAL]) begin
                        if (data_p0 <= 4'd9) begin
                            cells[cell_idx(row_reg, col_reg)] <= data_p0;
                            solved <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (flag_rise[F_COL]) begin
                        if (data_p0 >= 4'd1 && data_p0 <= 4'd9)
                            col_reg <= data_p0 - 4'd1;
                        else
                            err <= 1'b1;
                    end else if (flag_rise[F_ROW]) begin
                        if (data_p0 >= 4'd1 && data_p0 <= 4'd9)
                            row_reg <= data_p0 - 4'd1;
                        else
                            err <= 1'b1;
                    end
                end
                SCAN: begin
                    // Every scan visits all 243 cells; failures are only latched.
                    fail <= fail_next;
                    if (i_cnt == 4'd8) begin
                        mask  <= 9'd0;
                        i_cnt <= 4'd0;
                        if (g_cnt == 5'd26) begin
                            state      <= DONE;
                            busy       <= 1'b0;
                            check_done <= 1'b1;
                            solved     <= ~fail_next;
                        end else begin
                            g_cnt <= g_cnt + 5'd1;
                        end
                    end else begin
                        mask  <= mask | cur_bit;
                        i_cnt <= i_cnt + 4'd1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sudoku_board_checker.sv
// Directed bench for sudoku_board_checker: writes, rejects, full scans and
// reset/flag behaviour during a scan, checked with immediate assertions.
module tb_sudoku_board_checker;

    logic       clka = 1'b0;
    logic       restart_n;
    logic       set_board_flag, row_flag, col_flag, val_flag, check_flag;
    logic [3:0] data_in, rd_row, rd_col;
    logic [3:0] rd_val;
    logic       solved, busy, check_done, err;

    int n_cmp = 0;
    int n_bad = 0;
    int err_cnt = 0;
    logic [3:0] exp_b [0:80];

    sudoku_board_checker dut (
        .clka(clka), .restart_n(restart_n), .set_board_flag(set_board_flag),
        .row_flag(row_flag), .col_flag(col_flag), .val_flag(val_flag),
        .check_flag(check_flag), .data_in(data_in), .rd_row(rd_row),
        .rd_col(rd_col), .rd_val(rd_val), .solved(solved), .busy(busy),
        .check_done(check_done), .err(err)
    );

    always #5 clka = ~clka;

    always @(negedge clka) if (err === 1'b1) err_cnt++;

    function automatic logic [3:0] sol(input int r, input int c);
        return 4'(((r * 3 + r / 3 + c) % 9) + 1);
    endfunction

    task automatic check(input string tag, input int obs, input int exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic clear_flags();
        set_board_flag = 0; row_flag = 0; col_flag = 0; val_flag = 0; check_flag = 0;
    endtask

    task automatic pulse(input int which, input logic [3:0] d, input int hold);
        @(negedge clka);
        data_in = d;
        case (which)
            0: row_flag = 1;
            1: col_flag = 1;
            2: val_flag = 1;
            3: check_flag = 1;
            default: set_board_flag = 1;
        endcase
        repeat (hold) @(negedge clka);
        clear_flags();
        repeat (3) @(negedge clka);
    endtask

    task automatic write_cell(input int r, input int c, input logic [3:0] v);
        pulse(0, 4'(r + 1), 1);
        pulse(1, 4'(c + 1), 1);
        pulse(2, v, 1);
        exp_b[r * 9 + c] = v;
    endtask

    task automatic board_check(input string tag);
        int bad = 0;
        for (int k = 0; k < 81; k++) begin
            @(negedge clka);
            rd_row = 4'(k / 9);
            rd_col = 4'(k % 9);
            #1;
            if (rd_val !== exp_b[k]) bad++;
        end
        check(tag, bad, 0);
    endtask

    task automatic read_cell(input int r, input int c, output int v);
        @(negedge clka);
        rd_row = 4'(r);
        rd_col = 4'(c);
        #1;
        v = int'(rd_val);
    endtask

    task automatic run_check(input int val_at, output int busy_n, output int done_seen,
                             output int solv, output int busy_at_done);
        @(negedge clka);
        check_flag = 1;
        @(negedge clka);
        check_flag = 0;
        busy_n = 0;
        done_seen = 0;
        solv = -1;
        busy_at_done = -1;
        for (int k = 0; k < 400 && done_seen == 0; k++) begin
            @(negedge clka);
            if (k == val_at) begin
                data_in = 4'd3;
                val_flag = 1;
            end
            if (k == val_at + 2) val_flag = 0;
            if (check_done === 1'b1) begin
                done_seen = 1;
                solv = int'(solved);
                busy_at_done = int'(busy);
            end else if (busy === 1'b1) begin
                busy_n++;
            end
        end
        val_flag = 0;
        @(negedge clka);
    endtask

    int bn, dn, sv, bd, e0, v, done_cnt;

    initial begin
        restart_n = 0;
        clear_flags();
        data_in = 0;
        rd_row = 0;
        rd_col = 0;
        for (int k = 0; k < 81; k++) exp_b[k] = 4'd0;

        // Reset state
        repeat (3) @(negedge clka);
        check("rst_solved", int'(solved), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_check_done", int'(check_done), 0);
        check("rst_err", int'(err), 0);
        restart_n = 1;
        board_check("rst_board");

        // Level flags held for several cycles act once
        e0 = err_cnt;
        pulse(0, 4'd3, 5);
        pulse(1, 4'd5, 5);
        pulse(2, 4'd7, 5);
        exp_b[2 * 9 + 4] = 4'd7;
        board_check("level_write_board");
        check("level_no_err", err_cnt - e0, 0);

        // Rejected inputs
        e0 = err_cnt;
        pulse(0, 4'd0, 1);
        check("row0_err", err_cnt - e0, 1);
        pulse(1, 4'd1, 1);
        pulse(2, 4'd5, 1);
        exp_b[2 * 9 + 0] = 4'd5;
        read_cell(2, 0, v);
        check("prev_row_write", v, 5);
        e0 = err_cnt;
        pulse(2, 4'd12, 1);
        check("val12_err", err_cnt - e0, 1);
        read_cell(2, 0, v);
        check("val12_no_write", v, 5);
        e0 = err_cnt;
        pulse(1, 4'd10, 1);
        check("col10_err", err_cnt - e0, 1);

        // Board clear
        pulse(4, 4'd0, 1);
        for (int k = 0; k < 81; k++) exp_b[k] = 4'd0;
        board_check("set_board_clear");

        // Full valid grid
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                write_cell(r, c, sol(r, c));
        board_check("grid_written");
        rd_row = 4'd9; rd_col = 4'd0; #1;
        check("rd_row_oob", int'(rd_val), 0);
        rd_row = 4'd1; rd_col = 4'd12; #1;
        check("rd_col_oob", int'(rd_val), 0);

        run_check(-10, bn, dn, sv, bd);
        check("valid_busy_cycles", bn, 243);
        check("valid_done", dn, 1);
        check("valid_solved", sv, 1);
        check("valid_busy_at_done", bd, 0);
        check("done_one_cycle", int'(check_done), 0);
        check("solved_held", int'(solved), 1);

        pulse(2, sol(8, 8), 1);
        check("val_clears_solved", int'(solved), 0);

        // Swapped cells break the columns
        write_cell(0, 0, sol(0, 1));
        write_cell(0, 1, sol(0, 0));
        run_check(-10, bn, dn, sv, bd);
        check("swap_done", dn, 1);
        check("swap_solved", sv, 0);

        // Restore; a val edge mid-scan must be ignored
        write_cell(0, 0, sol(0, 0));
        write_cell(0, 1, sol(0, 1));
        e0 = err_cnt;
        run_check(50, bn, dn, sv, bd);
        check("scanval_solved", sv, 1);
        check("scanval_no_err", err_cnt - e0, 0);
        read_cell(8, 8, v);
        check("scanval_cell", v, int'(sol(8, 8)));
        board_check("scanval_board");

        pulse(4, 4'd0, 1);
        check("set_board_clears_solved", int'(solved), 0);
        for (int k = 0; k < 81; k++) exp_b[k] = 4'd0;

        // Empty board
        run_check(-10, bn, dn, sv, bd);
        check("empty_done", dn, 1);
        check("empty_solved", sv, 0);

        // Reset in the middle of a scan
        write_cell(4, 4, 4'd5);
        @(negedge clka);
        check_flag = 1;
        @(negedge clka);
        check_flag = 0;
        repeat (100) @(negedge clka);
        check("busy_mid_scan", int'(busy), 1);
        restart_n = 0;
        #1;
        check("rst_mid_busy", int'(busy), 0);
        @(negedge clka);
        restart_n = 1;
        done_cnt = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clka);
            if (check_done === 1'b1) done_cnt++;
        end
        check("rst_mid_no_done", done_cnt, 0);
        for (int k = 0; k < 81; k++) exp_b[k] = 4'd0;
        board_check("rst_mid_board");
        check("rst_mid_solved", int'(solved), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sudoku_board_checker.md
# sudoku_board_checker

Board-storage and solution-check datapath that responds to the Sudoku main FSM's control flags. It holds the 9x9 playing grid and captures row, column and value from the shared 4-bit switch input on the FSM's `row_flag`, `col_flag` and `val_flag` strobes. On `check_flag` it scans all 27 constraint groups sequentially and returns the `solved` level that the FSM samples.

## Interface
- No parameters. Grid is fixed at 9x9 with 4-bit cells; value 0 means empty.
- Ports:
- `clka` — in, 1 — system clock; rising-edge.
- `restart_n` — in, 1 — asynchronous, active-low reset.
- `set_board_flag` — in, 1 — FSM flag; on its rising edge the board is cleared.
- `row_flag` — in, 1 — FSM flag; capture the row from `data_in`.
- `col_flag` — in, 1 — FSM flag; capture the column from `data_in`.
- `val_flag` — in, 1 — FSM flag; write `data_in` to cell (row, col).
- `check_flag` — in, 1 — FSM flag; start a board scan.
- `data_in` — in, 4 — switch value; 1-based for row and column.
- `rd_row` — in, 4 — display read row, 0-8.
- `rd_col` — in, 4 — display read column, 0-8.
- `rd_val` — out, 4 — combinational cell[rd_row][rd_col]; reads 0 if the index is above 8.
- `solved` — out, 1 — registered result of the last completed scan.
- `busy` — out, 1 — high while a scan is in progress.
- `check_done` — out, 1 — one-cycle pulse when a scan completes.
- `err` — out, 1 — one-cycle pulse when an input is rejected.

## Operation
- **Edge detection.** Each flag is registered, and the block acts only on its rising edge (flag high and previous-cycle flag low). A flag held high for many cycles produces exactly one action. All previous-flag registers reset to 0.
- **States:** IDLE, SCAN, DONE.
- **IDLE.** Flag edges are acted on with priority `set_board` > `check` > `val` > `col` > `row`. Only the highest-priority edge in a cycle acts; lower-priority edges in the same cycle are dropped.
- **set_board.** All 81 cells are set to 0 and `solved` is set to 0. The row and column registers are unchanged.
- **row / col.** `data_in` in 1..9 is stored as `data_in`-1 in a 4-bit register. A value of 0 or 10..15 leaves the register unchanged and pulses `err`.
- **val.** `data_in` in 0..9 is written to cell[row_reg][col_reg], and `solved` is cleared. A value of 10..15 does not write and pulses `err`.
- **check.** Goes to SCAN with group counter g=0 and cell counter i=0; `busy`=1 and the seen-mask is cleared.
- **SCAN.** Processes one cell per cycle in group order:
  - g 0-8: row g, cell (g, i).
  - g 9-17: column g-9, cell (i, g-9).
  - g 18-26: box b=g-18, cell (3*(b/3)+i/3, 3*(b%3)+i%3).
  - Per cell: if the value is 0 or its bit is already set in the 9-bit seen-mask, the sticky `fail` flag is set; otherwise the bit is set.
  - When i=8, the mask is cleared for the next group. i wraps 8→0 and increments g.
  - There is no early abort: every scan is exactly 243 cells.
- **SCAN → DONE.** After processing g=26, i=8, the state moves to DONE and `solved` is loaded with !fail.
- **DONE.** `check_done`=1 and `busy`=0 for one cycle, then the state returns to IDLE.
- **Flags during SCAN/DONE.** All flag edges are ignored (no write, no `err`), but the previous-flag registers keep tracking.
- **Reset** (any time, including mid-scan):
  - all cells 0; row and column registers 0;
  - `solved`, `busy`, `check_done` and `err` all 0;
  - state IDLE; counters and mask 0.

## Timing
- A rising edge of a flag sampled at clock edge N takes effect at edge N+1: register or cell updated, `err` high for the cycle after N+1.
- **Check latency.**
  - check edge sampled at edge N; `busy` rises after edge N+1.
  - Cell k (0..242) is processed at edge N+2+k.
  - `solved` updates and `check_done` is high in the cycle after edge N+244; `busy` is low in that cycle.
- `rd_val` is combinational from the cell array and reflects a write in the cycle after the write edge.
- A `val` write landing in the same cycle as a check edge loses on priority; the check runs on the unchanged board.

## Test plan
- **Reset.** Hold `restart_n`=0, then release → `rd_val`=0 at all 81 addresses; `solved`/`busy`/`check_done`/`err` = 0.
- **Single write, level flags.**
  - Sequence: `row_flag` high 5 cycles with `data_in`=3, `col_flag` with 5, `val_flag` with 7.
  - Required: `rd_row`=2, `rd_col`=4 reads 7; every other cell reads 0; exactly one write occurs.
- **Invalid input.**
  - row edge with `data_in`=0 → `err` pulses 1 cycle; a later write goes to the previous row.
  - val edge with `data_in`=12 → `err` pulses; the cell is unchanged.
- **Valid solution.**
  - Write a complete valid grid (81 writes), then a check edge.
  - Required: `busy` high 243 cycles, then `check_done` pulses with `solved`=1.
  - A following `val` write clears `solved` to 0.
- **Invalid boards, both → `check_done` pulses with `solved`=0:**
  - the same grid with cells (0,0) and (0,1) swapped;
  - an empty board.
- **Reset and flags during SCAN.**
  - A `val` edge during SCAN → board unchanged, no `err`.
  - `restart_n` low at scan cycle 100 → `busy` drops immediately, board reads 0, and no `check_done` follows.
